i2c_xfer_sequencer: RTL and testbench
=====================================

Name: i2c_xfer_sequencer

Overview:
- Wishbone master that drives the team's byte-oriented I2C master core through its register map (PRERlo 0, PRERhi 1, CTR 2, TXR/RXR 3, CR/SR 4).
- Converts one high-level register-access request (device, register, data, read/write) into the full command/poll sequence and returns a single response with a status code.
- Sits between firmware-facing glue and the I2C master core, so software never programs CR or polls SR directly.

Parameters:
- PRESCALE, 16'd99: value written to PRERhi:PRERlo at init (100 kHz SCL at 50 MHz).
- TIMEOUT_POLLS, 16'd4096: maximum SR reads per byte phase before timeout is declared.

Ports:
- wb_clk_i  in  1  clock
- arst_i  in  1  reset
- req_valid  in  1  request valid
- req_ready  out  1  sequencer can accept a request
- req_rnw  in  1  1 = read, 0 = write
- req_dev  in  7  7-bit slave address
- req_reg  in  8  slave register index
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  8  read data; 0 on writes and on errors
- rsp_err  out  2  00 ok, 01 NACK, 10 arbitration lost, 11 timeout
- m_wb_adr_o  out  3  core register address
- m_wb_dat_o  out  8  write data to core
- m_wb_dat_i  in  8  read data from core
- m_wb_we_o  out  1  write enable
- m_wb_stb_o  out  1  strobe
- m_wb_cyc_o  out  1  cycle
- m_wb_ack_i  in  1  core acknowledge
- core_inta_i  in  1  core interrupt (used only when the optional feature is compiled in)
- busy_o  out  1  high from request accept to response

Behaviour:
- Reset: arst_i, asynchronous, active-high; clock wb_clk_i.
- While arst_i is high, all outputs are 0; the FSM is in INIT and all counters are 0.
- Wishbone master:
  - Classic single transfer: cyc/stb/we/adr/dat are held stable until m_wb_ack_i.
  - The bus drops cyc/stb on the cycle after ack. No back-to-back strobes.
  - Read data is captured on the ack cycle.
- INIT (once after reset): write PRERlo = PRESCALE[7:0], then PRERhi = PRESCALE[15:8], then CTR = 0x80. Then go to IDLE.
- IDLE: req_ready = 1. Accept on req_valid & req_ready and latch all req_* fields. req_ready is 0 in every other state.
- Byte phase, applied per micro-op:
  - Write TXR.
  - Write CR.
  - Enter POLL and read SR repeatedly until TIP (bit 1) = 0.
  - On the SR read with TIP = 0:
    - AL (bit 5) = 1 → go to RESP with err 10 and issue no STOP.
    - Otherwise RxACK (bit 7) = 1 on an address or write phase → go to ABORT with err 01.
    - Otherwise continue to the next phase.
- Write sequence:
  1. TXR = {dev,0}, CR = 0x90 (STA|WR).
  2. TXR = reg, CR = 0x10.
  3. TXR = wdata, CR = 0x50 (STO|WR).
- Read sequence:
  1. TXR = {dev,0}, CR = 0x90.
  2. TXR = reg, CR = 0x10.
  3. TXR = {dev,1}, CR = 0x90 (repeated start).
  4. CR = 0x68 (RD|ACK|STO; NACK on the last byte).
  5. Poll, then read RXR into rsp_rdata.
  - RxACK is ignored on the data-read phase.
- ABORT: write CR = 0x40 (STO), poll until TIP = 0, then go to RESP.
- Timeout: the poll counter resets at the start of each phase.
  - When the counter reaches TIMEOUT_POLLS with TIP still 1, write CTR = 0x00 then CTR = 0x80 (core soft-disable), then go to RESP with err 11.
- RESP: rsp_valid = 1 for exactly one cycle, then return to IDLE. rsp_err and rsp_rdata hold their values until the next response.
- A new req_valid during the response cycle is not accepted; accept no earlier than the cycle after.
- Reset mid-transfer: all state is abandoned immediately, no response is issued, and INIT reruns.

Optional Feature:
- I2C_XFER_SEQ_IRQ_EN
- Defined:
  - POLL waits for core_inta_i = 1 instead of reading SR continuously.
  - It then reads SR once and writes CR = 0x01 (IACK) before evaluating the result.
  - INIT writes CTR = 0xC0 (EN|IEN).
  - The timeout counts clock cycles waiting for core_inta_i, scaled by TIMEOUT_POLLS × 4.
- Undefined: SR polling as above; core_inta_i is unused.

Decomposition:
- Package i2c_xfer_pkg holds:
  - register address constants;
  - CR command constants (0x90, 0x10, 0x50, 0x68, 0x40, 0x01);
  - SR bit indices (RXACK 7, BUSY 6, AL 5, TIP 1, IF 0);
  - the rsp_err enum;
  - the FSM state enum.
- Sub-module i2c_xfer_wb_master: a single-transfer Wishbone master.
  - Inputs: start, we, adr, wdata.
  - Outputs: done pulse, rdata.
  - The sequencer FSM issues one operation at a time through it.

Test Plan:
- Reset release with PRESCALE = 99 → bus writes in order: adr0 = 0x63, adr1 = 0x00, adr2 = 0x80; then req_ready = 1.
- Write req dev = 0x50, reg = 0x10, data = 0xA5, with a core model acking every byte → TXR writes 0xA0, 0x10, 0xA5; CR writes 0x90, 0x10, 0x50; rsp_err = 00; rsp_valid pulses once.
- Read req dev = 0x50, reg = 0x02, core returns RXR = 0x3C → TXR 0xA0, 0x02, 0xA1; CR 0x90, 0x10, 0x90, 0x68; rsp_rdata = 0x3C, err = 00.
- Address NACK (SR = 0x80 with TIP = 0 after the first phase) → CR = 0x40 issued; rsp_err = 01; rsp_rdata = 0.
- AL set in SR (0x20) after the second phase → no STOP write; rsp_err = 10. Separately, TIP stuck at 1 with TIMEOUT_POLLS = 8 → 8 SR reads, then CTR 0x00 and 0x80, rsp_err = 11.
- arst_i pulsed mid-poll → cyc/stb drop immediately; no rsp_valid; INIT sequence repeats.

Source files
------------

// File: rtl/i2c_xfer_sequencer_pkg.sv
// Shared constants and types for the I2C transfer sequencer: core register map,
// CR command bytes, SR bit positions, response codes and FSM states.
package i2c_xfer_pkg;

  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXR    = 3'd3;
  localparam logic [2:0] ADR_RXR    = 3'd3;
  localparam logic [2:0] ADR_CR     = 3'd4;
  localparam logic [2:0] ADR_SR     = 3'd4;

  localparam logic [7:0] CR_STA_WR      = 8'h90;
  localparam logic [7:0] CR_WR          = 8'h10;
  localparam logic [7:0] CR_STO_WR      = 8'h50;
  localparam logic [7:0] CR_RD_NACK_STO = 8'h68;
  localparam logic [7:0] CR_STO         = 8'h40;
  localparam logic [7:0] CR_IACK        = 8'h01;

  localparam logic [7:0] CTR_OFF    = 8'h00;
  localparam logic [7:0] CTR_EN     = 8'h80;
  localparam logic [7:0] CTR_EN_IEN = 8'hC0;

  localparam int unsigned SR_RXACK = 7;
  localparam int unsigned SR_BUSY  = 6;
  localparam int unsigned SR_AL    = 5;
  localparam int unsigned SR_TIP   = 1;
  localparam int unsigned SR_IF    = 0;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_AL      = 2'b10,
    ERR_TIMEOUT = 2'b11
  } rsp_err_e;

  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_TXR, ST_CR, ST_POLL, ST_IACK, ST_EVAL,
    ST_RXR, ST_ABORT, ST_TO_DIS, ST_TO_EN, ST_RESP
  } state_e;

endpackage

// File: rtl/i2c_xfer_sequencer_if.sv
// Request/response handshake and Wishbone master bus of the I2C transfer sequencer.
// master = sequencer side, slave = firmware glue plus I2C core side.
interface i2c_xfer_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rnw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [2:0] m_wb_adr_o;
  logic [7:0] m_wb_dat_o;
  logic [7:0] m_wb_dat_i;
  logic       m_wb_we_o;
  logic       m_wb_stb_o;
  logic       m_wb_cyc_o;
  logic       m_wb_ack_i;

  modport master (
    input  req_valid, req_rnw, req_dev, req_reg, req_wdata, m_wb_dat_i, m_wb_ack_i,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_stb_o, m_wb_cyc_o
  );

  modport slave (
    output req_valid, req_rnw, req_dev, req_reg, req_wdata, m_wb_dat_i, m_wb_ack_i,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_stb_o, m_wb_cyc_o
  );
endinterface

// File: rtl/i2c_xfer_sequencer_wb_master.sv
// Single-transfer classic Wishbone master: one start pulse -> one bus cycle,
// cyc/stb drop the cycle after ack, done pulses then with the captured read data.
module i2c_xfer_wb_master (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       start,
  input  logic       we,
  input  logic [2:0] adr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic [2:0] m_wb_adr_o,
  output logic [7:0] m_wb_dat_o,
  input  logic [7:0] m_wb_dat_i,
  output logic       m_wb_we_o,
  output logic       m_wb_stb_o,
  output logic       m_wb_cyc_o,
  input  logic       m_wb_ack_i
);

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      done       <= 1'b0;
      rdata      <= '0;
      m_wb_adr_o <= '0;
      m_wb_dat_o <= '0;
      m_wb_we_o  <= 1'b0;
      m_wb_stb_o <= 1'b0;
      m_wb_cyc_o <= 1'b0;
    end else begin
      done <= 1'b0;
      if (m_wb_cyc_o) begin
        if (m_wb_ack_i) begin
          m_wb_cyc_o <= 1'b0;
          m_wb_stb_o <= 1'b0;
          m_wb_we_o  <= 1'b0;
          done       <= 1'b1;
          rdata      <= m_wb_dat_i;
        end
      end else if (start) begin
        m_wb_cyc_o <= 1'b1;
        m_wb_stb_o <= 1'b1;
        m_wb_we_o  <= we;
        m_wb_adr_o <= adr;
        m_wb_dat_o <= wdata;
      end
    end
  end

endmodule

// File: rtl/i2c_xfer_sequencer.sv
// Turns one register-access request into the I2C core CR/TXR/SR command sequence.
// Optional build macro I2C_XFER_SEQ_IRQ_EN: wait on core_inta_i instead of SR polling.
module i2c_xfer_sequencer
  import i2c_xfer_pkg::*;
#(
  parameter logic [15:0] PRESCALE      = 16'd99,
  parameter logic [15:0] TIMEOUT_POLLS = 16'd4096
) (
  input  logic                  wb_clk_i,
  input  logic                  arst_i,
  i2c_xfer_sequencer_if.master  bus,
  input  logic                  core_inta_i,
  output logic                  busy_o
);

`ifdef I2C_XFER_SEQ_IRQ_EN
  localparam logic [17:0] TO_LIMIT = {TIMEOUT_POLLS, 2'b00};
  localparam logic [7:0]  CTR_ON   = CTR_EN_IEN;
`else
  localparam logic [17:0] TO_LIMIT = {2'b00, TIMEOUT_POLLS};
  localparam logic [7:0]  CTR_ON   = CTR_EN;
  logic inta_unused;
  assign inta_unused = core_inta_i;
`endif

  state_e     state;
  rsp_err_e   err_q;
  logic [2:0] phase;
  logic       pend, aborting, rnw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wdata_q, rdata_q;
  logic [17:0] cnt;
  logic       sr_tip, sr_al, sr_rxack;
  logic       start, done;
  logic [7:0] wb_rdata;
  logic       op_state, op_we, issue, last_phase;
  logic [2:0] op_adr;
  logic [7:0] op_dat;

  assign last_phase = rnw_q ? (phase == 3'd3) : (phase == 3'd2);

  always_comb begin
    op_state = 1'b1;
    op_we    = 1'b1;
    op_adr   = ADR_CR;
    op_dat   = '0;
    case (state)
      ST_INIT: begin
        case (phase)
          3'd0:    begin op_adr = ADR_PRERLO; op_dat = PRESCALE[7:0];  end
          3'd1:    begin op_adr = ADR_PRERHI; op_dat = PRESCALE[15:8]; end
          default: begin op_adr = ADR_CTR;    op_dat = CTR_ON;         end
        endcase
      end
      ST_TXR: begin
        op_adr = ADR_TXR;
        case (phase)
          3'd0:    op_dat = {dev_q, 1'b0};
          3'd1:    op_dat = reg_q;
          default: op_dat = rnw_q ? {dev_q, 1'b1} : wdata_q;
        endcase
      end
      ST_CR: begin
        case (phase)
          3'd0:    op_dat = CR_STA_WR;
          3'd1:    op_dat = CR_WR;
          3'd2:    op_dat = rnw_q ? CR_STA_WR : CR_STO_WR;
          default: op_dat = CR_RD_NACK_STO;
        endcase
      end
      ST_ABORT:  op_dat = CR_STO;
      ST_IACK:   op_dat = CR_IACK;
      ST_POLL:   begin op_we = 1'b0; op_adr = ADR_SR;  end
      ST_RXR:    begin op_we = 1'b0; op_adr = ADR_RXR; end
      ST_TO_DIS: begin op_adr = ADR_CTR; op_dat = CTR_OFF; end
      ST_TO_EN:  begin op_adr = ADR_CTR; op_dat = CTR_ON;  end
      default:   begin op_state = 1'b0; op_we = 1'b0; end
    endcase
  end

`ifdef I2C_XFER_SEQ_IRQ_EN
  assign issue = op_state && !pend && (state != ST_POLL || core_inta_i);
`else
  assign issue = op_state && !pend;
`endif

  i2c_xfer_wb_master u_wb (
    .wb_clk_i   (wb_clk_i),
    .arst_i     (arst_i),
    .start      (start),
    .we         (op_we),
    .adr        (op_adr),
    .wdata      (op_dat),
    .done       (done),
    .rdata      (wb_rdata),
    .m_wb_adr_o (bus.m_wb_adr_o),
    .m_wb_dat_o (bus.m_wb_dat_o),
    .m_wb_dat_i (bus.m_wb_dat_i),
    .m_wb_we_o  (bus.m_wb_we_o),
    .m_wb_stb_o (bus.m_wb_stb_o),
    .m_wb_cyc_o (bus.m_wb_cyc_o),
    .m_wb_ack_i (bus.m_wb_ack_i)
  );

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      state         <= ST_INIT;
      err_q         <= ERR_OK;
      phase         <= '0;
      pend          <= 1'b0;
      aborting      <= 1'b0;
      rnw_q         <= 1'b0;
      dev_q         <= '0;
      reg_q         <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      cnt           <= '0;
      sr_tip        <= 1'b0;
      sr_al         <= 1'b0;
      sr_rxack      <= 1'b0;
      start         <= 1'b0;
      busy_o        <= 1'b0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= '0;
      bus.rsp_rdata <= '0;
    end else begin
      start         <= 1'b0;
      bus.rsp_valid <= 1'b0;
      if (issue) begin
        start <= 1'b1;
        pend  <= 1'b1;
      end
      if (done) pend <= 1'b0;

      case (state)
        ST_INIT: if (done) begin
          phase <= (phase == 3'd2) ? 3'd0 : phase + 3'd1;
          if (phase == 3'd2) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.req_ready && bus.req_valid) begin
            bus.req_ready <= 1'b0;
            busy_o   <= 1'b1;
            rnw_q    <= bus.req_rnw;
            dev_q    <= bus.req_dev;
            reg_q    <= bus.req_reg;
            wdata_q  <= bus.req_wdata;
            rdata_q  <= '0;
            err_q    <= ERR_OK;
            aborting <= 1'b0;
            phase    <= '0;
            state    <= ST_TXR;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        ST_TXR: if (done) state <= ST_CR;
        ST_CR, ST_ABORT: if (done) begin
          cnt   <= '0;
          state <= ST_POLL;
        end
        ST_POLL: begin
          if (done) begin
            sr_tip   <= wb_rdata[SR_TIP];
            sr_al    <= wb_rdata[SR_AL];
            sr_rxack <= wb_rdata[SR_RXACK];
`ifdef I2C_XFER_SEQ_IRQ_EN
            state    <= ST_IACK;
          end else if (!pend && !core_inta_i) begin
            // Interrupt wait: each idle cycle counts against the scaled timeout.
            if (cnt == TO_LIMIT - 18'd1) state <= ST_TO_DIS;
            else cnt <= cnt + 18'd1;
`else
            state    <= ST_EVAL;
`endif
          end
        end
        ST_IACK: if (done) state <= ST_EVAL;
        ST_EVAL: begin
          if (sr_tip) begin
            if (cnt == TO_LIMIT - 18'd1) state <= ST_TO_DIS;
            else begin
              cnt   <= cnt + 18'd1;
              state <= ST_POLL;
            end
          end else if (aborting) begin
            state <= ST_RESP;
          end else if (sr_al) begin
            err_q <= ERR_AL;
            state <= ST_RESP;
          end else if (sr_rxack && !(rnw_q && phase == 3'd3)) begin
            err_q    <= ERR_NACK;
            aborting <= 1'b1;
            state    <= ST_ABORT;
          end else if (last_phase) begin
            state <= rnw_q ? ST_RXR : ST_RESP;
          end else begin
            // Read phase 3 is the data read: CR only, TXR is not reloaded.
            phase <= phase + 3'd1;
            state <= (rnw_q && phase == 3'd2) ? ST_CR : ST_TXR;
          end
        end
        ST_RXR: if (done) begin
          rdata_q <= wb_rdata;
          state   <= ST_RESP;
        end
        ST_TO_DIS: if (done) state <= ST_TO_EN;
        ST_TO_EN: if (done) begin
          err_q <= ERR_TIMEOUT;
          state <= ST_RESP;
        end
        ST_RESP: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= err_q;
          bus.rsp_rdata <= rdata_q;
          busy_o        <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Scoreboard bench: a behavioural I2C core answers the Wishbone bus; expected bus
// operations and responses are queued by the stimulus and popped by a monitor.
module tb_i2c_xfer_sequencer;

  logic clk = 1'b0;
  logic arst = 1'b0;
  logic inta = 1'b0;
  logic busy;

  i2c_xfer_sequencer_if bus_if();

  i2c_xfer_sequencer #(.PRESCALE(16'd99), .TIMEOUT_POLLS(16'd8)) dut (
    .wb_clk_i    (clk),
    .arst_i      (arst),
    .bus         (bus_if.master),
    .core_inta_i (inta),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [2:0] adr; logic [7:0] dat; } op_t;
  typedef struct packed { logic [1:0] err; logic [7:0] rdata; } rsp_t;

  op_t  exp_ops[$];
  rsp_t exp_rsp[$];
  int   total = 0;
  int   bad = 0;
  int   mode = 0;       // 0 all ACK, 1 address NACK, 2 AL after phase 2, 3 TIP stuck
  int   tip_left = 0;
  int   cr_count = 0;
  int   sr_reads = 0;
  logic rsp_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] final_sr(input int m, input int c);
    if (m == 1 && c == 1) return 8'h80;
    if (m == 2 && c == 2) return 8'h20;
    return 8'h00;
  endfunction

  // I2C core model: one-cycle ack, two TIP=1 SR reads after every CR command.
  always @(posedge clk or posedge arst) begin
    if (arst) begin
      bus_if.m_wb_ack_i <= 1'b0;
      bus_if.m_wb_dat_i <= 8'h00;
      tip_left <= 0;
      cr_count <= 0;
      sr_reads <= 0;
    end else begin
      if (bus_if.req_valid && bus_if.req_ready) begin
        cr_count <= 0;
        tip_left <= 0;
      end
      if (bus_if.m_wb_cyc_o && bus_if.m_wb_stb_o && !bus_if.m_wb_ack_i) begin
        bus_if.m_wb_ack_i <= 1'b1;
        if (bus_if.m_wb_we_o) begin
          bus_if.m_wb_dat_i <= 8'h00;
          if (bus_if.m_wb_adr_o == 3'd4 && bus_if.m_wb_dat_o != 8'h01) begin
            cr_count <= cr_count + 1;
            tip_left <= 2;
          end
        end else if (bus_if.m_wb_adr_o == 3'd4) begin
          sr_reads <= sr_reads + 1;
          if (mode == 3) bus_if.m_wb_dat_i <= 8'h02;
          else if (tip_left > 0) begin
            bus_if.m_wb_dat_i <= 8'h02;
            tip_left <= tip_left - 1;
          end else bus_if.m_wb_dat_i <= final_sr(mode, cr_count);
        end else begin
          bus_if.m_wb_dat_i <= 8'h3C;
        end
      end else begin
        bus_if.m_wb_ack_i <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!arst) begin
      if (bus_if.m_wb_cyc_o && bus_if.m_wb_stb_o && bus_if.m_wb_ack_i) begin
        if (exp_ops.size() == 0) begin
          total++;
          bad++;
          $display("FAIL op_extra: got we=%0d adr=%0d dat=%02h want none",
                   bus_if.m_wb_we_o, bus_if.m_wb_adr_o, bus_if.m_wb_dat_o);
        end else begin
          op_t e;
          e = exp_ops.pop_front();
          check("bus_op", 32'({bus_if.m_wb_we_o, bus_if.m_wb_adr_o,
                bus_if.m_wb_we_o ? bus_if.m_wb_dat_o : 8'h00}), 32'(e));
        end
      end
      if (bus_if.rsp_valid) begin
        check("rsp_ready_low", 32'(bus_if.req_ready), 32'd0);
        check("rsp_pulse", 32'(rsp_prev), 32'd0);
        if (exp_rsp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_extra: got err=%0d rdata=%02h want none",
                   bus_if.rsp_err, bus_if.rsp_rdata);
        end else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          check("rsp", 32'({bus_if.rsp_err, bus_if.rsp_rdata}), 32'(r));
        end
      end
      rsp_prev = bus_if.rsp_valid;
    end
  end

  task automatic exp_w(input logic [2:0] a, input logic [7:0] d);
    exp_ops.push_back({1'b1, a, d});
  endtask

  task automatic exp_polls(input int n);
    repeat (n) exp_ops.push_back({1'b0, 3'd4, 8'h00});
  endtask

  task automatic exp_phase(input logic [7:0] txr, input logic [7:0] cr);
    exp_w(3'd3, txr);
    exp_w(3'd4, cr);
    exp_polls(3);
  endtask

  task automatic exp_init();
    exp_w(3'd0, 8'h63);
    exp_w(3'd1, 8'h00);
    exp_w(3'd2, 8'h80);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (!(exp_ops.size() == 0 && exp_rsp.size() == 0 && bus_if.req_ready) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < limit), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic send(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                      input logic [7:0] wd);
    int n = 0;
    while (!bus_if.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 32'(bus_if.req_ready), 32'd1);
    bus_if.req_valid = 1'b1;
    bus_if.req_rnw   = rnw;
    bus_if.req_dev   = dev;
    bus_if.req_reg   = rg;
    bus_if.req_wdata = wd;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    bus_if.req_valid = 1'b0;
    bus_if.req_rnw   = 1'b0;
    bus_if.req_dev   = '0;
    bus_if.req_reg   = '0;
    bus_if.req_wdata = '0;
    #1 arst = 1'b1;
    #1;
    check("rst_cyc", 32'(bus_if.m_wb_cyc_o), 32'd0);
    check("rst_stb", 32'(bus_if.m_wb_stb_o), 32'd0);
    check("rst_we", 32'(bus_if.m_wb_we_o), 32'd0);
    check("rst_adr", 32'(bus_if.m_wb_adr_o), 32'd0);
    check("rst_dat", 32'(bus_if.m_wb_dat_o), 32'd0);
    check("rst_ready", 32'(bus_if.req_ready), 32'd0);
    check("rst_rsp", 32'({bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_rdata}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    exp_init();
    arst = 1'b0;
    wait_idle("init", 100);

    // write dev 0x50 reg 0x10 data 0xA5
    mode = 0;
    exp_phase(8'hA0, 8'h90);
    exp_phase(8'h10, 8'h10);
    exp_phase(8'hA5, 8'h50);
    exp_rsp.push_back({2'b00, 8'h00});
    send(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_idle("write", 400);

    // read dev 0x50 reg 0x02, RXR = 0x3C
    exp_phase(8'hA0, 8'h90);
    exp_phase(8'h02, 8'h10);
    exp_phase(8'hA1, 8'h90);
    exp_w(3'd4, 8'h68);
    exp_polls(3);
    exp_ops.push_back({1'b0, 3'd3, 8'h00});
    exp_rsp.push_back({2'b00, 8'h3C});
    send(1'b1, 7'h50, 8'h02, 8'h00);
    wait_idle("read", 400);

    // address NACK -> STOP, err 01
    mode = 1;
    exp_phase(8'hA0, 8'h90);
    exp_w(3'd4, 8'h40);
    exp_polls(3);
    exp_rsp.push_back({2'b01, 8'h00});
    send(1'b0, 7'h50, 8'h10, 8'h11);
    wait_idle("nack", 400);

    // arbitration lost after register phase -> no STOP, err 10
    mode = 2;
    exp_phase(8'hA0, 8'h90);
    exp_phase(8'h02, 8'h10);
    exp_rsp.push_back({2'b10, 8'h00});
    send(1'b1, 7'h50, 8'h02, 8'h00);
    wait_idle("arb_lost", 400);
    repeat (5) @(negedge clk);

    // TIP stuck -> 8 SR reads, CTR 00/80, err 11
    mode = 3;
    exp_w(3'd3, 8'hA0);
    exp_w(3'd4, 8'h90);
    exp_polls(8);
    exp_w(3'd2, 8'h00);
    exp_w(3'd2, 8'h80);
    exp_rsp.push_back({2'b11, 8'h00});
    send(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_idle("timeout", 400);

    // reset while an SR read is in flight
    exp_w(3'd3, 8'hA0);
    exp_w(3'd4, 8'h90);
    exp_polls(3);
    base = sr_reads;
    send(1'b0, 7'h50, 8'h10, 8'hA5);
    n = 0;
    while (!(sr_reads == base + 3 && bus_if.m_wb_cyc_o && !bus_if.m_wb_ack_i) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_poll_reached", 32'(n < 200), 32'd1);
    arst = 1'b1;
    #1;
    check("arst_cyc", 32'(bus_if.m_wb_cyc_o), 32'd0);
    check("arst_stb", 32'(bus_if.m_wb_stb_o), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ops_left", 32'(exp_ops.size()), 32'd0);
    exp_ops.delete();
    mode = 0;
    repeat (2) @(negedge clk);
    exp_init();
    arst = 1'b0;
    wait_idle("reinit", 100);

    // normal write after re-init
    exp_phase(8'hA0, 8'h90);
    exp_phase(8'h33, 8'h10);
    exp_phase(8'h5A, 8'h50);
    exp_rsp.push_back({2'b00, 8'h00});
    send(1'b0, 7'h50, 8'h33, 8'h5A);
    wait_idle("write2", 400);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
